nexus_work_scheduler: RTL
=========================

# nexus_work_scheduler

Sequences one pipelined Nexus SK1024 hash core (`NexusHashTransform`) through work units. It accepts a work packet with a start nonce and nonce range from the host, then holds the core in reset while loading it. It releases the core for exactly the requested number of issue cycles and drains the pipeline. Found nonces are accepted only while they belong to the issued range, are buffered in a 2-entry result FIFO, and new work may pre-empt a running unit at any time.

## Interface
- `PIPE_DEPTH`, 391: core latency in cycles from nonce issue to `GoodNonceFound`/`NonceOut`.
- `RANGE_W`, 32: width of the nonce-range count.
- `clk`  in  1  sole clock; all logic on posedge.
- `HashRst`  in  1  asynchronous, active-high reset.
- `WorkValid`  in  1  host offers work.
- `WorkReady`  out  1  scheduler accepts work this cycle (registered).
- `WorkPktIn`  in  1728  midstate + header tail.
- `StartNonce`  in  64  first nonce of the unit.
- `WorkRange`  in  RANGE_W  issue cycles; 0 means 2^RANGE_W.
- `Abort`  in  1  stop the current unit.
- `CoreRstN`  out  1  drives core `nHashRst`.
- `CoreWorkPkt`  out  1728  latched packet to the core.
- `CoreInNonce`  out  64  latched start nonce to the core.
- `CoreNonce`  in  64  core `NonceOut`.
- `CoreFound`  in  1  core `GoodNonceFound`.
- `ResValid`  out  1  FIFO head valid.
- `ResReady`  in  1  host pops the head.
- `ResNonce`  out  64  FIFO head nonce.
- `Busy`  out  1  state is not IDLE.
- `WorkDone`  out  1  one-cycle pulse when a unit completes normally.
- `DropCnt`  out  16  saturating count of found nonces lost to a full FIFO.

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- Accept condition: `WorkValid && WorkReady`. `WorkReady` is 1 in IDLE, RUN and DRAIN, and 0 in LOAD and during reset.
- On accept, from any state:
  - latch `WorkPktIn`, `StartNonce` and `WorkRange` (0 is mapped to 2^RANGE_W internally, using RANGE_W+1 bits);
  - set `CoreRstN`=0 and go to LOAD.
- LOAD lasts exactly 2 cycles with `CoreRstN`=0, then goes to RUN with `CoreRstN`=1.
- Cycle counter `Cyc` (RANGE_W+1 bits plus room for PIPE_DEPTH) is 0 on the first cycle `CoreRstN`=1 and increments every cycle.
- RUN becomes DRAIN when `Cyc` = range−1.
- DRAIN ends at `Cyc` = range+PIPE_DEPTH−1. On the next cycle: IDLE, `CoreRstN`=0, `WorkDone`=1 for that one cycle.
- Found window: `CoreFound` is accepted only when state is RUN/DRAIN and PIPE_DEPTH ≤ `Cyc` < range+PIPE_DEPTH. Outside the window it is ignored and not counted.
- Accepted nonce behaviour:
  - pushed to the FIFO if it is not full;
  - if full, it is discarded and `DropCnt` increments, saturating at 0xFFFF.
  - Push and pop in the same cycle with the FIFO full is legal: no drop.
- `Abort` in RUN/DRAIN goes to IDLE next cycle with `CoreRstN`=0 and no `WorkDone`. `Abort` in IDLE/LOAD is ignored.
- `Abort` together with an accepted `WorkValid`: the work is accepted and `Abort` is ignored.
- FIFO contents and `DropCnt` survive pre-emption, abort and completion. Only `HashRst` clears them.

## Timing
- Reset values: state IDLE, `WorkReady`=0, `CoreRstN`=0, `CoreWorkPkt`/`CoreInNonce`=0, `ResValid`=0, `ResNonce`=0, `Busy`=0, `WorkDone`=0, `DropCnt`=0, FIFO empty.
- `WorkReady` rises on the first posedge after `HashRst` deasserts.
- Accept at cycle T: `CoreRstN`=0 during T+1 and T+2, and 1 from T+3, where `Cyc`=0.
- A nonce found for issue cycle k arrives at `Cyc`=k+PIPE_DEPTH. It is pushed that edge and `ResValid` is high the next cycle.
- `ResNonce` is stable while `ResValid && !ResReady`. A pop advances the head the next cycle.
- Unit duration from accept to `WorkDone`: 2 + range + PIPE_DEPTH + 1 cycles.
- Asserting `HashRst` mid-unit clears everything immediately (asynchronous), with `CoreRstN` low at once.

## Test plan
All scenarios use PIPE_DEPTH=8 and a stub core that echoes StartNonce+k with `CoreFound` at issue cycle k after 8 cycles.
- Normal unit: StartNonce=0x1FCAFC044, WorkRange=4, finds at k=1 and k=3 -> `ResNonce` 0x1FCAFC045 then 0x1FCAFC047; `WorkDone` pulses 15 cycles after accept; `DropCnt`=0.
- Window gating: stub asserts `CoreFound` at `Cyc`=3 and at `Cyc`=12 with WorkRange=4 -> no push; FIFO stays empty.
- Overflow: WorkRange=4, all 4 found, `ResReady`=0 -> FIFO holds k=0 and k=1; `DropCnt`=2; a later pop returns 0x1FCAFC044 then 0x1FCAFC045.
- Pre-emption: new work (StartNonce=0x100) accepted at `Cyc`=5 of a WorkRange=100 unit -> `CoreRstN` low for 2 cycles; old-unit finds after the accept are ignored; `CoreInNonce`=0x100; no `WorkDone` for the first unit.
- Abort plus simultaneous work: `Abort`=1 and `WorkValid`=1 in RUN -> state LOAD. `Abort` alone in DRAIN -> IDLE, `CoreRstN`=0, `WorkDone` stays 0.
- Async reset mid-RUN with 1 FIFO entry -> all outputs take their reset values immediately; `WorkReady`=1 one cycle after release.

Source files
------------

// File: rtl/nexus_work_scheduler.sv
// rtl/nexus_work_scheduler.sv - work-unit sequencer for one pipelined SK1024 hash core
module nexus_work_scheduler #(
    parameter int PIPE_DEPTH = 391,
    parameter int RANGE_W    = 32
) (
    input  logic               clk,
    input  logic               HashRst,
    input  logic               WorkValid,
    output logic               WorkReady,
    input  logic [1727:0]      WorkPktIn,
    input  logic [63:0]        StartNonce,
    input  logic [RANGE_W-1:0] WorkRange,
    input  logic               Abort,
    output logic               CoreRstN,
    output logic [1727:0]      CoreWorkPkt,
    output logic [63:0]        CoreInNonce,
    input  logic [63:0]        CoreNonce,
    input  logic               CoreFound,
    output logic               ResValid,
    input  logic               ResReady,
    output logic [63:0]        ResNonce,
    output logic               Busy,
    output logic               WorkDone,
    output logic [15:0]        DropCnt
);

    // range needs one extra bit so that 0 can stand for 2^RANGE_W; the cycle
    // counter also has to reach range + PIPE_DEPTH
    localparam int RNG_W = RANGE_W + 1;
    localparam int CYC_W = RANGE_W + 2 + $clog2(PIPE_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [RNG_W-1:0]    r_range;
    logic [CYC_W-1:0]    r_cyc;
    logic                r_load_cnt;
    logic                r_work_ready;
    logic                r_core_rstn;
    logic                r_work_done;
    logic [1727:0]       r_pkt;
    logic [63:0]         r_nonce;
    logic [63:0]         r_fifo [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_count;
    logic [15:0]         r_drop;

    logic                w_accept;
    logic                w_active;
    logic [CYC_W-1:0]    w_range_ext;
    logic [CYC_W-1:0]    w_pipe;
    logic                w_run_last;
    logic                w_drain_last;
    logic                w_in_window;
    logic                w_unit_done;
    logic                w_hit;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    assign w_accept     = WorkValid && r_work_ready;
    assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_range_ext  = CYC_W'(r_range);
    assign w_pipe       = CYC_W'(PIPE_DEPTH);
    assign w_run_last   = (r_cyc == w_range_ext - CYC_W'(1));
    assign w_drain_last = (r_cyc == w_range_ext + w_pipe - CYC_W'(1));
    // results only belong to this unit once the first issued nonce has
    // crossed the pipeline and until the last one has
    assign w_in_window  = w_active && (r_cyc >= w_pipe) && (r_cyc < w_range_ext + w_pipe);
    assign w_unit_done  = (r_state == S_DRAIN) && w_drain_last && !w_accept && !Abort;

    assign w_hit  = CoreFound && w_in_window;
    assign w_pop  = (r_count != 2'd0) && ResReady;
    assign w_push = w_hit && ((r_count != 2'd2) || w_pop);
    assign w_drop = w_hit && (r_count == 2'd2) && !w_pop;

    assign WorkReady   = r_work_ready;
    assign CoreRstN    = r_core_rstn;
    assign CoreWorkPkt = r_pkt;
    assign CoreInNonce = r_nonce;
    assign ResValid    = (r_count != 2'd0);
    assign ResNonce    = r_fifo[r_rd_ptr];
    assign Busy        = (r_state != S_IDLE);
    assign WorkDone    = r_work_done;
    assign DropCnt     = r_drop;

    // next state: new work pre-empts everything, abort only stops a running unit
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_LOAD:  w_state_nxt = r_load_cnt ? S_RUN : S_LOAD;
                S_RUN:   w_state_nxt = Abort ? S_IDLE : (w_run_last ? S_DRAIN : S_RUN);
                S_DRAIN: w_state_nxt = (Abort || w_drain_last) ? S_IDLE : S_DRAIN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or posedge HashRst) begin
        if (HashRst) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // registered control outputs, load timer and cycle counter
    always_ff @(posedge clk or posedge HashRst) begin
        if (HashRst) begin
            r_work_ready <= 1'b0;
            r_core_rstn  <= 1'b0;
            r_work_done  <= 1'b0;
            r_load_cnt   <= 1'b0;
            r_cyc        <= '0;
        end else begin
            r_work_ready <= (w_state_nxt != S_LOAD);
            r_core_rstn  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_work_done  <= w_unit_done;
            r_load_cnt   <= (r_state == S_LOAD) ? ~r_load_cnt : 1'b0;
            if (r_state == S_LOAD) r_cyc <= '0;
            else if (w_active)     r_cyc <= r_cyc + CYC_W'(1);
        end
    end

    // work latch presented to the core while it is held in reset
    always_ff @(posedge clk or posedge HashRst) begin
        if (HashRst) begin
            r_pkt   <= '0;
            r_nonce <= '0;
            r_range <= '0;
        end else if (w_accept) begin
            r_pkt   <= WorkPktIn;
            r_nonce <= StartNonce;
            r_range <= (WorkRange == '0) ? {1'b1, {RANGE_W{1'b0}}} : {1'b0, WorkRange};
        end
    end

    // 2-entry result FIFO and saturating drop counter
    always_ff @(posedge clk or posedge HashRst) begin
        if (HashRst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_drop    <= 16'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= CoreNonce;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
        end
    end

endmodule
